// File: rtl/ip_pkg.sv
// Shared constants, state encoding and header word builder for the IPv4 header sequencer.
package ip_pkg;

  localparam logic [7:0]  VER_IHL    = 8'h45;
  localparam logic [15:0] FLAGS_FRAG = 16'h4000;
  localparam int          HDR_WORDS  = 5;
  localparam logic [2:0]  LAST_WORD  = 3'(HDR_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FOLD  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  // Word order is the on-wire big-endian field order of a 20-byte header.
  function automatic logic [31:0] hdr_word(
    input logic [2:0]  idx,
    input logic [7:0]  ttl,
    input logic [7:0]  proto,
    input logic [15:0] total_len,
    input logic [15:0] id,
    input logic [15:0] csum,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip
  );
    logic [31:0] w;
    case (idx)
      3'd0:    w = {VER_IHL, 8'h00, total_len};
      3'd1:    w = {id, FLAGS_FRAG};
      3'd2:    w = {ttl, proto, csum};
      3'd3:    w = src_ip;
      default: w = dst_ip;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ip_csum_accum.sv
// 20-bit ones'-complement accumulator with a two-stage end-around-carry fold.
// csum is valid two cycles after the last enab and stays put while the accumulator is idle.
module ip_csum_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enab,
  input  logic [31:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc_q, acc_d;
  logic [16:0] s1_q, s1_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] s2;

  // Ten 16-bit halves sum to at most 10 x FFFF, which fits in 20 bits.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enab) begin
      acc_d = acc_q + 20'(word[31:16]) + 20'(word[15:0]);
    end
    s1_d   = 17'(acc_q[15:0]) + 17'(acc_q[19:16]);
    // A carry out of s1 leaves at most 16'h000E below it, so s2 cannot carry again.
    s2     = s1_q[15:0] + 16'(s1_q[16]);
    csum_d = ~s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      s1_q   <= '0;
      csum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      s1_q   <= s1_d;
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/ip_header_sequencer.sv
// Builds one IPv4 header per request: checksum pass over the five words, fold, then stream.
//   state    | meaning
//   ST_IDLE  | req_ready high, waiting for a request
//   ST_ACCUM | feeding W0..W4 (checksum field zero) into the accumulator
//   ST_FOLD  | two cycles for the checksum fold pipeline
//   ST_EMIT  | streaming W0..W4 downstream under valid/ready
module ip_header_sequencer
  import ip_pkg::*;
#(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic [7:0]  PROTO   = 8'd17,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_total_len,
  input  logic [31:0] req_src_ip,
  input  logic [31:0] req_dst_ip,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [31:0] hdr_data,
  output logic        hdr_last,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] id_q, id_d;
  logic [15:0] len_q, len_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic        req_ready_q, req_ready_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        hdr_last_q, hdr_last_d;
  logic        busy_q, busy_d;
  logic [31:0] hdr_data_q, hdr_data_d;

  logic        acc_clear;
  logic        acc_enab;
  logic [31:0] acc_word;
  logic [15:0] csum;

  ip_csum_accum u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .enab  (acc_enab),
    .word  (acc_word),
    .csum  (csum)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    len_d       = len_q;
    src_d       = src_q;
    dst_d       = dst_q;
    req_ready_d = req_ready_q;
    hdr_valid_d = hdr_valid_q;
    hdr_last_d  = hdr_last_q;
    busy_d      = busy_q;
    hdr_data_d  = hdr_data_q;
    acc_clear   = 1'b0;
    acc_enab    = 1'b0;
    acc_word    = hdr_word(cnt_q, TTL, PROTO, len_q, id_q, 16'h0000, src_q, dst_q);

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          len_d       = req_total_len;
          src_d       = req_src_ip;
          dst_d       = req_dst_ip;
          acc_clear   = 1'b1;
          cnt_d       = 3'd0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_enab = 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d   = 3'd0;
          state_d = ST_FOLD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_FOLD: begin
        // W0 carries no checksum, so it can be loaded on the same edge that registers C.
        if (cnt_q == 3'd1) begin
          cnt_d       = 3'd0;
          hdr_valid_d = 1'b1;
          hdr_last_d  = 1'b0;
          hdr_data_d  = hdr_word(3'd0, TTL, PROTO, len_q, id_q, csum, src_q, dst_q);
          state_d     = ST_EMIT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_EMIT: begin
        if (hdr_valid_q && hdr_ready) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d       = 3'd0;
            hdr_valid_d = 1'b0;
            hdr_last_d  = 1'b0;
            hdr_data_d  = '0;
            busy_d      = 1'b0;
            req_ready_d = 1'b1;
            id_d        = id_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            hdr_data_d = hdr_word(cnt_q + 3'd1, TTL, PROTO, len_q, id_q, csum, src_q, dst_q);
            hdr_last_d = ((cnt_q + 3'd1) == LAST_WORD);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= ID_INIT;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      req_ready_q <= 1'b0;
      hdr_valid_q <= 1'b0;
      hdr_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      hdr_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      req_ready_q <= req_ready_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_last_q  <= hdr_last_d;
      busy_q      <= busy_d;
      hdr_data_q  <= hdr_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign hdr_valid = hdr_valid_q;
  assign hdr_last  = hdr_last_q;
  assign busy      = busy_q;
  assign hdr_data  = hdr_data_q;

endmodule
